// File: rtl/oflow_mem_wr_collector.sv
// MEM buffer write collector: gathers even/odd bbox results from two PE lanes through
// 2-entry FIFOs, issues paired writes into the rotating history slot, then pulses done_write.
module oflow_mem_wr_collector #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned BBOX_CNT_WIDTH = 6,
  parameter int unsigned HIST_WIDTH     = 3
) (
  input  logic                      clk,
  input  logic                      reset_N,
  input  logic                      start_write,
  input  logic [BBOX_CNT_WIDTH-1:0] num_of_bbox_in_frame,
  input  logic [HIST_WIDTH-1:0]     num_of_history_frames,
  input  logic                      pe_valid_0,
  input  logic                      pe_valid_1,
  input  logic [DATA_WIDTH-1:0]     pe_data_0,
  input  logic [DATA_WIDTH-1:0]     pe_data_1,
  output logic                      pe_ready_0,
  output logic                      pe_ready_1,
  output logic                      we_0,
  output logic                      we_1,
  output logic [DATA_WIDTH-1:0]     data_in_0,
  output logic [DATA_WIDTH-1:0]     data_in_1,
  output logic [BBOX_CNT_WIDTH-1:0] offset_0,
  output logic [BBOX_CNT_WIDTH-1:0] offset_1,
  output logic [HIST_WIDTH-1:0]     wr_frame_slot,
  output logic                      done_write,
  output logic                      busy,
  output logic                      err_start_busy
);

  localparam int unsigned DW = DATA_WIDTH;
  localparam int unsigned BW = BBOX_CNT_WIDTH;
  localparam int unsigned HW = HIST_WIDTH;
  localparam int unsigned CW = 2;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DONE    = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [DW-1:0]   fifo_mem_q [2][2];
  logic [DW-1:0]   fifo_mem_d [2][2];
  logic [1:0]      fifo_wp_q, fifo_wp_d;
  logic [1:0]      fifo_rp_q, fifo_rp_d;
  logic [CW-1:0]   fifo_cnt_q [2];
  logic [CW-1:0]   fifo_cnt_d [2];
  logic [BW-1:0]   quota_q [2];
  logic [BW-1:0]   quota_d [2];
  logic [BW-1:0]   acc_q [2];
  logic [BW-1:0]   acc_d [2];
  logic [BW-1:0]   rem_q, rem_d;
  logic [BW-1:0]   wr_idx_q, wr_idx_d;
  logic [1:0]      rdy_q, rdy_d;
  logic            we_0_q, we_0_d, we_1_q, we_1_d;
  logic [DW-1:0]   data_in_0_q, data_in_0_d, data_in_1_q, data_in_1_d;
  logic [BW-1:0]   offset_0_q, offset_0_d, offset_1_q, offset_1_d;
  logic [HW-1:0]   slot_q, slot_d;
  logic            done_write_q, done_write_d;
  logic            busy_q, busy_d;
  logic            err_q, err_d;

  logic [1:0]      push;
  logic [1:0]      pop;
  logic [DW-1:0]   lane_data [2];
  logic [DW-1:0]   head [2];

  assign lane_data[0] = pe_data_0;
  assign lane_data[1] = pe_data_1;
  assign head[0]      = fifo_mem_q[0][fifo_rp_q[0]];
  assign head[1]      = fifo_mem_q[1][fifo_rp_q[1]];

  // Next-state, FIFO bookkeeping and registered-output computation
  always_comb begin
    state_d      = state_q;
    fifo_mem_d   = fifo_mem_q;
    fifo_wp_d    = fifo_wp_q;
    fifo_rp_d    = fifo_rp_q;
    fifo_cnt_d   = fifo_cnt_q;
    quota_d      = quota_q;
    acc_d        = acc_q;
    rem_d        = rem_q;
    wr_idx_d     = wr_idx_q;
    rdy_d        = '0;
    we_0_d       = 1'b0;
    we_1_d       = 1'b0;
    data_in_0_d  = data_in_0_q;
    data_in_1_d  = data_in_1_q;
    offset_0_d   = offset_0_q;
    offset_1_d   = offset_1_q;
    slot_d       = slot_q;
    err_d        = err_q;
    pop          = '0;
    push         = {pe_valid_1, pe_valid_0} & rdy_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_write) begin
          // a start coinciding with done_write still belongs to the finishing frame
          if (done_write_q) begin
            err_d = 1'b1;
          end else begin
            quota_d[0] = (num_of_bbox_in_frame >> 1) + BW'(num_of_bbox_in_frame[0]);
            quota_d[1] = num_of_bbox_in_frame >> 1;
            acc_d[0]   = '0;
            acc_d[1]   = '0;
            wr_idx_d   = '0;
            rem_d      = num_of_bbox_in_frame;
            state_d    = (num_of_bbox_in_frame == '0) ? S_DONE : S_COLLECT;
          end
        end
      end
      S_COLLECT: begin
        if (start_write) err_d = 1'b1;
        if ((fifo_cnt_q[0] != '0) && ((fifo_cnt_q[1] != '0) || (rem_q == BW'(1)))) begin
          we_0_d      = 1'b1;
          data_in_0_d = head[0];
          offset_0_d  = wr_idx_q;
          pop[0]      = 1'b1;
          if (rem_q == BW'(1)) begin
            offset_1_d = '0;
            rem_d      = '0;
          end else begin
            we_1_d      = 1'b1;
            data_in_1_d = head[1];
            offset_1_d  = wr_idx_q + BW'(1);
            pop[1]      = 1'b1;
            wr_idx_d    = wr_idx_q + BW'(2);
            rem_d       = rem_q - BW'(2);
          end
          if (rem_d == '0) state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (start_write) err_d = 1'b1;
        slot_d  = (slot_q >= num_of_history_frames) ? '0 : slot_q + HW'(1);
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    for (int k = 0; k < 2; k++) begin
      if (push[k]) begin
        fifo_mem_d[k][fifo_wp_q[k]] = lane_data[k];
        fifo_wp_d[k]                = ~fifo_wp_q[k];
      end
      if (pop[k]) fifo_rp_d[k] = ~fifo_rp_q[k];
      fifo_cnt_d[k] = fifo_cnt_q[k] + CW'(push[k]) - CW'(pop[k]);
      acc_d[k]      = acc_d[k] + BW'(push[k]);
      // ready is computed from next-cycle state so the registered copy never lags
      rdy_d[k]      = (state_d == S_COLLECT) && (fifo_cnt_d[k] != CW'(2)) &&
                      (acc_d[k] < quota_d[k]);
    end

    busy_d       = (state_d == S_COLLECT);
    done_write_d = (state_q == S_DONE);
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q      <= S_IDLE;
      for (int k = 0; k < 2; k++) begin
        fifo_mem_q[k][0] <= '0;
        fifo_mem_q[k][1] <= '0;
        fifo_cnt_q[k]    <= '0;
        quota_q[k]       <= '0;
        acc_q[k]         <= '0;
      end
      fifo_wp_q    <= '0;
      fifo_rp_q    <= '0;
      rem_q        <= '0;
      wr_idx_q     <= '0;
      rdy_q        <= '0;
      we_0_q       <= 1'b0;
      we_1_q       <= 1'b0;
      data_in_0_q  <= '0;
      data_in_1_q  <= '0;
      offset_0_q   <= '0;
      offset_1_q   <= '0;
      slot_q       <= '0;
      done_write_q <= 1'b0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      fifo_mem_q   <= fifo_mem_d;
      fifo_cnt_q   <= fifo_cnt_d;
      quota_q      <= quota_d;
      acc_q        <= acc_d;
      fifo_wp_q    <= fifo_wp_d;
      fifo_rp_q    <= fifo_rp_d;
      rem_q        <= rem_d;
      wr_idx_q     <= wr_idx_d;
      rdy_q        <= rdy_d;
      we_0_q       <= we_0_d;
      we_1_q       <= we_1_d;
      data_in_0_q  <= data_in_0_d;
      data_in_1_q  <= data_in_1_d;
      offset_0_q   <= offset_0_d;
      offset_1_q   <= offset_1_d;
      slot_q       <= slot_d;
      done_write_q <= done_write_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

  assign pe_ready_0     = rdy_q[0];
  assign pe_ready_1     = rdy_q[1];
  assign we_0           = we_0_q;
  assign we_1           = we_1_q;
  assign data_in_0      = data_in_0_q;
  assign data_in_1      = data_in_1_q;
  assign offset_0       = offset_0_q;
  assign offset_1       = offset_1_q;
  assign wr_frame_slot  = slot_q;
  assign done_write     = done_write_q;
  assign busy           = busy_q;
  assign err_start_busy = err_q;

endmodule
